// File: rtl/floo_pkg.sv
// Shared types for the FlooNoC progress monitor.
// Holds the monitor FSM state encoding.
package floo_pkg;

  localparam int unsigned MonStateW = 2;

  typedef enum logic [MonStateW-1:0] {
    MON_IDLE    = 2'd0,
    MON_RUN     = 2'd1,
    MON_DONE    = 2'd2,
    MON_TIMEOUT = 2'd3
  } monitor_state_e;

endpackage

// File: rtl/floo_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module floo_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/floo_progress_monitor.sv
// Watches per-lane completions and done flags of a NoC run,
// declaring DONE when all lanes finish or TIMEOUT on a stall.
module floo_progress_monitor
  import floo_pkg::*;
#(
  parameter int unsigned NumNodes      = 4,
  parameter int unsigned NumChans      = 2,
  parameter int unsigned CntWidth      = 32,
  parameter int unsigned TimeoutCycles = 10000,
  localparam int unsigned L            = NumNodes * NumChans,
  localparam int unsigned IdleW        = $clog2(TimeoutCycles)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [L-1:0]          done_i,
  input  logic [L-1:0]          cpl_i,
  output logic [1:0]            state_o,
  output logic                  all_done_o,
  output logic                  timeout_o,
  output logic [L-1:0]          done_mask_o,
  output logic [L*CntWidth-1:0] cpl_cnt_o,
  output logic [IdleW-1:0]      idle_cnt_o
);

  localparam logic [IdleW-1:0] IdleMax = IdleW'(TimeoutCycles - 1);

  monitor_state_e   r_state, w_state_nxt;
  logic [L-1:0]     r_mask, w_mask_nxt;
  logic [IdleW-1:0] r_idle, w_idle_nxt;

  logic w_run;
  logic w_any_cpl;
  logic w_idle_max;
  logic w_all_done;
  logic w_cnt_clr;

  assign w_run      = (r_state == MON_RUN);
  assign w_any_cpl  = |cpl_i;
  assign w_idle_max = (r_idle == IdleMax);
  assign w_all_done = &(r_mask | done_i);
  assign w_cnt_clr  = clear_i | (r_state == MON_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= MON_IDLE;
      r_mask  <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  // Idle count saturates so a DONE win at the limit keeps it at max
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_idle_nxt  = r_idle;
    if (clear_i) begin
      w_state_nxt = MON_IDLE;
      w_mask_nxt  = '0;
      w_idle_nxt  = '0;
    end else begin
      unique case (r_state)
        MON_IDLE: begin
          if (start_i) w_state_nxt = MON_RUN;
        end
        MON_RUN: begin
          w_mask_nxt = r_mask | done_i;
          if (w_any_cpl) begin
            w_idle_nxt = '0;
          end else if (!w_idle_max) begin
            w_idle_nxt = r_idle + IdleW'(1);
          end
          if (w_all_done) begin
            w_state_nxt = MON_DONE;
          end else if (!w_any_cpl && w_idle_max) begin
            w_state_nxt = MON_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lane
    floo_sat_counter #(
      .Width(CntWidth)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (w_cnt_clr),
      .inc   (w_run & cpl_i[g]),
      .cnt_o (cpl_cnt_o[g*CntWidth +: CntWidth])
    );
  end

  assign state_o     = r_state;
  assign all_done_o  = (r_state == MON_DONE);
  assign timeout_o   = (r_state == MON_TIMEOUT);
  assign done_mask_o = r_mask;
  assign idle_cnt_o  = r_idle;

endmodule

// File: tb/tb_floo_progress_monitor.sv
// Self-checking bench for floo_progress_monitor: directed
// scenarios plus a randomized run against a reference model.
module tb_floo_progress_monitor;

  localparam int NN   = 4;
  localparam int NC   = 2;
  localparam int L    = NN * NC;
  localparam int CW   = 4;
  localparam int TO   = 16;
  localparam int IW   = $clog2(TO);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [L-1:0]  done = '0;
  logic [L-1:0]  cpl = '0;
  logic [1:0]    state;
  logic          all_done;
  logic          tmo;
  logic [L-1:0]  mask;
  logic [L*CW-1:0] cnts;
  logic [IW-1:0] idle;

  int errors = 0;
  int checks = 0;

  int           m_state;
  int           m_idle;
  logic [L-1:0] m_mask;
  int           m_cnt [L];

  floo_progress_monitor #(
    .NumNodes(NN),
    .NumChans(NC),
    .CntWidth(CW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .clear_i     (clear),
    .done_i      (done),
    .cpl_i       (cpl),
    .state_o     (state),
    .all_done_o  (all_done),
    .timeout_o   (tmo),
    .done_mask_o (mask),
    .cpl_cnt_o   (cnts),
    .idle_cnt_o  (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] lane_cnt(int i);
    return cnts[i*CW +: CW];
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_idle  = 0;
    m_mask  = '0;
    for (int i = 0; i < L; i++) m_cnt[i] = 0;
  endtask

  // One clock cycle: drive inputs, advance model, sample 1 after edge
  task automatic step(input logic s, input logic c,
                      input logic [L-1:0] d, input logic [L-1:0] p);
    logic [L-1:0] nm;
    @(negedge clk);
    start = s;
    clear = c;
    done  = d;
    cpl   = p;
    if (c) begin
      model_reset();
    end else if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 1) begin
      for (int i = 0; i < L; i++)
        if (p[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      nm = m_mask | d;
      if ($countones(nm) == L) m_state = 2;
      else if (p == 0 && m_idle == TO - 1) m_state = 3;
      if (p != 0) m_idle = 0;
      else if (m_idle < TO - 1) m_idle = m_idle + 1;
      m_mask = nm;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    done  = '0;
    cpl   = '0;
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 2'd0 || all_done !== 1'b0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags state=%0d all_done=%b tmo=%b want 0/0/0",
               state, all_done, tmo);
    end
    checks++;
    if (mask !== '0 || idle !== '0 || cnts !== '0) begin
      errors++;
      $display("FAIL reset_regs mask=%h idle=%0d cnts=%h want zeros",
               mask, idle, cnts);
    end
  endtask

  task automatic test_all_done();
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL ad_run state=%0d want 1", state);
    end
    for (int c = 1; c < 5; c++) step(0, 0, '0, '0);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL ad_still_run state=%0d want 1", state);
    end
    step(0, 0, 8'hFF, '0);
    checks++;
    if (state !== 2'd2 || all_done !== 1'b1 || tmo !== 1'b0
        || mask !== 8'hFF || idle !== IW'(5)) begin
      errors++;
      $display("FAIL ad_done state=%0d ad=%b tmo=%b mask=%h idle=%0d want 2/1/0/ff/5",
               state, all_done, tmo, mask, idle);
    end
    step(1, 0, 8'h00, 8'hFF);
    step(0, 0, 8'h00, 8'h0F);
    checks++;
    if (state !== 2'd2 || cnts !== '0 || idle !== IW'(5)) begin
      errors++;
      $display("FAIL ad_frozen state=%0d cnts=%h idle=%0d want 2/0/5",
               state, cnts, idle);
    end
  endtask

  task automatic test_timeout();
    int n;
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    n = 0;
    while (tmo !== 1'b1 && n < 40) begin
      step(0, 0, '0, '0);
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL to_latency cycles=%0d want %0d", n, TO);
    end
    checks++;
    if (state !== 2'd3 || idle !== IW'(TO - 1) || all_done !== 1'b0) begin
      errors++;
      $display("FAIL to_state state=%0d idle=%0d ad=%b want 3/%0d/0",
               state, idle, all_done, TO - 1);
    end
    step(0, 0, 8'hFF, 8'hFF);
    step(1, 0, '0, 8'h01);
    checks++;
    if (state !== 2'd3 || idle !== IW'(TO - 1) || cnts !== '0 || mask !== '0) begin
      errors++;
      $display("FAIL to_frozen state=%0d idle=%0d cnts=%h mask=%h",
               state, idle, cnts, mask);
    end
  endtask

  task automatic test_saturation();
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    for (int c = 0; c < 20; c++) step(0, 0, '0, 8'h08);
    for (int i = 0; i < L; i++) begin
      checks++;
      if (lane_cnt(i) !== ((i == 3) ? CW'(CMAX) : CW'(0))) begin
        errors++;
        $display("FAIL sat_lane%0d got=%h want=%h", i, lane_cnt(i),
                 (i == 3) ? CMAX : 0);
      end
    end
    checks++;
    if (state !== 2'd1 || idle !== '0) begin
      errors++;
      $display("FAIL sat_state state=%0d idle=%0d want 1/0", state, idle);
    end
  endtask

  task automatic test_race();
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    step(0, 0, 8'h7F, '0);
    for (int c = 0; c < TO - 2; c++) step(0, 0, '0, '0);
    checks++;
    if (state !== 2'd1 || idle !== IW'(TO - 1)) begin
      errors++;
      $display("FAIL race_pre state=%0d idle=%0d want 1/%0d",
               state, idle, TO - 1);
    end
    step(0, 0, 8'h80, '0);
    checks++;
    if (state !== 2'd2 || tmo !== 1'b0 || all_done !== 1'b1 || mask !== 8'hFF) begin
      errors++;
      $display("FAIL race_done state=%0d tmo=%b ad=%b mask=%h want 2/0/1/ff",
               state, tmo, all_done, mask);
    end
  endtask

  task automatic test_clear();
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    for (int k = 0; k < 4; k++) step(0, 0, L'(1 << k), L'(1 << k));
    checks++;
    if (mask !== 8'h0F || lane_cnt(2) !== CW'(1)) begin
      errors++;
      $display("FAIL clr_pre mask=%h cnt2=%0d want 0f/1", mask, lane_cnt(2));
    end
    step(0, 1, 8'h10, 8'h10);
    checks++;
    if (state !== 2'd0 || mask !== '0 || cnts !== '0 || idle !== '0) begin
      errors++;
      $display("FAIL clr_idle state=%0d mask=%h cnts=%h idle=%0d want zeros",
               state, mask, cnts, idle);
    end
    step(1, 0, '0, '0);
    checks++;
    if (state !== 2'd1 || mask !== '0 || cnts !== '0 || idle !== '0) begin
      errors++;
      $display("FAIL clr_restart state=%0d mask=%h cnts=%h idle=%0d want 1/0/0/0",
               state, mask, cnts, idle);
    end
    step(1, 1, 8'h01, 8'h01);
    checks++;
    if (state !== 2'd0 || cnts !== '0) begin
      errors++;
      $display("FAIL clr_prio state=%0d cnts=%h want 0/0", state, cnts);
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, '0, '0);
    step(1, 0, '0, '0);
    step(0, 0, 8'h03, 8'h05);
    step(0, 0, '0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || all_done !== 1'b0 || tmo !== 1'b0
        || mask !== '0 || cnts !== '0 || idle !== '0) begin
      errors++;
      $display("FAIL arst_mid state=%0d mask=%h cnts=%h idle=%0d want zeros",
               state, mask, cnts, idle);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 0, 8'hFF, 8'hFF);
    checks++;
    if (state !== 2'd0 || mask !== '0 || cnts !== '0) begin
      errors++;
      $display("FAIL arst_wait state=%0d mask=%h cnts=%h want 0/0/0",
               state, mask, cnts);
    end
    step(1, 0, '0, '0);
    checks++;
    if (state !== 2'd1 || cnts !== '0 || idle !== '0) begin
      errors++;
      $display("FAIL arst_restart state=%0d cnts=%h idle=%0d want 1/0/0",
               state, cnts, idle);
    end
  endtask

  task automatic test_random();
    logic s, c;
    logic [L-1:0] d, p;
    int mode;
    step(0, 1, '0, '0);
    mode = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) mode = $urandom_range(0, 2);
      s = (m_state == 1) ? ($urandom_range(0, 9) == 0)
                         : ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 59) == 0)
          || (m_state >= 2 && $urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 15) == 0) ? L'(1 << $urandom_range(0, L - 1)) : '0;
      case (mode)
        0:       p = L'($urandom & $urandom);
        1:       p = ($urandom_range(0, 19) == 0)
                     ? L'(1 << $urandom_range(0, L - 1)) : '0;
        default: p = '0;
      endcase
      step(s, c, d, p);
      checks++;
      if (state !== 2'(m_state)) begin
        errors++;
        $display("FAIL rnd_state n=%0d got=%0d want=%0d", n, state, m_state);
      end
      checks++;
      if (all_done !== (m_state == 2) || tmo !== (m_state == 3)) begin
        errors++;
        $display("FAIL rnd_flags n=%0d ad=%b tmo=%b model_state=%0d",
                 n, all_done, tmo, m_state);
      end
      checks++;
      if (mask !== m_mask) begin
        errors++;
        $display("FAIL rnd_mask n=%0d got=%h want=%h", n, mask, m_mask);
      end
      checks++;
      if (idle !== IW'(m_idle)) begin
        errors++;
        $display("FAIL rnd_idle n=%0d got=%0d want=%0d", n, idle, m_idle);
      end
      for (int i = 0; i < L; i++) begin
        checks++;
        if (lane_cnt(i) !== CW'(m_cnt[i])) begin
          errors++;
          $display("FAIL rnd_cnt n=%0d lane=%0d got=%0d want=%0d",
                   n, i, lane_cnt(i), m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_all_done();
    test_timeout();
    test_saturation();
    test_race();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
